// File: rtl/sobel_row_loader_pkg.sv
// Shared sobel definitions: data widths, minimum strip height
// and the row-loader state encoding.
package sobel_row_loader_pkg;

   localparam int NUM_SOBEL_ACCELERATORS = 4;
   localparam int SOBEL_IDATA_WIDTH = (NUM_SOBEL_ACCELERATORS + 2) * 8;
   localparam int MIN_ROWS = 3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FILL1  = 3'd1;
   localparam logic [2:0] ST_FILL2  = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;

endpackage

// File: rtl/sobel_row_loader_window.sv
// Three-row shift window; rows only move when a new segment
// is pushed in, so a stalled window stays stable.
module sobel_row_window
   import sobel_row_loader_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         shift,
   input  logic [SOBEL_IDATA_WIDTH-1:0] din,
   output logic [SOBEL_IDATA_WIDTH-1:0] row1,
   output logic [SOBEL_IDATA_WIDTH-1:0] row2,
   output logic [SOBEL_IDATA_WIDTH-1:0] row3
);

   always_ff @(posedge clk) begin
      if (reset) begin
         row1 <= '0;
         row2 <= '0;
         row3 <= '0;
      end else if (shift) begin
         row1 <= row2;
         row2 <= row3;
         row3 <= din;
      end
   end

endmodule

// File: rtl/sobel_row_loader.sv
// Row-window loader between the sobel read unit and the
// accelerator core: FSM, row counter and output handshake.
module sobel_row_loader
   import sobel_row_loader_pkg::*;
#(
   parameter int ROW_CNT_WIDTH = 16
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [ROW_CNT_WIDTH-1:0]     cfg_num_rows,
   input  logic                         srd2srow_valid,
   input  logic [SOBEL_IDATA_WIDTH-1:0] srd2srow_data,
   output logic                         srow2srd_ready,
   output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row1_data,
   output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row2_data,
   output logic [SOBEL_IDATA_WIDTH-1:0] srow2sacc_row3_data,
   output logic                         srow2sacc_valid,
   input  logic                         swt2srow_ready,
   output logic                         srow_strip_done,
   output logic                         srow_busy
);

   localparam logic [ROW_CNT_WIDTH-1:0] CNT_ONE = ROW_CNT_WIDTH'(1);
   localparam logic [ROW_CNT_WIDTH-1:0] CNT_MIN = ROW_CNT_WIDTH'(MIN_ROWS);

   logic [2:0]               state;
   logic [ROW_CNT_WIDTH-1:0] num_rows;
   logic [ROW_CNT_WIDTH-1:0] row_cnt;
   logic                     win_valid;
   logic                     done_q;
   logic                     loading;
   logic                     accept;
   logic                     consume;
   logic                     last_accept;

   assign loading = (state == ST_FILL1) || (state == ST_FILL2) ||
                    (state == ST_STREAM);

   // Counter is capped by num_rows, so the +1 below never wraps.
   assign srow2srd_ready = loading && (row_cnt < num_rows) &&
                           (!win_valid || swt2srow_ready);

   assign accept      = srd2srow_valid && srow2srd_ready;
   assign consume     = win_valid && swt2srow_ready;
   assign last_accept = accept && ((row_cnt + CNT_ONE) == num_rows);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         num_rows  <= '0;
         row_cnt   <= '0;
         win_valid <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (accept)
            row_cnt <= row_cnt + CNT_ONE;

         if (accept && state == ST_STREAM)
            win_valid <= 1'b1;
         else if (consume)
            win_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_num_rows >= CNT_MIN) begin
                     num_rows <= cfg_num_rows;
                     row_cnt  <= '0;
                     state    <= ST_FILL1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_FILL1: if (accept) state <= ST_FILL2;
            ST_FILL2: if (accept) state <= ST_STREAM;
            ST_STREAM: if (last_accept) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (consume) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sobel_row_window u_window (
      .clk   (clk),
      .reset (reset),
      .shift (accept),
      .din   (srd2srow_data),
      .row1  (srow2sacc_row1_data),
      .row2  (srow2sacc_row2_data),
      .row3  (srow2sacc_row3_data)
   );

   assign srow2sacc_valid = win_valid;
   assign srow_strip_done = done_q;
   assign srow_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_sobel_row_loader.sv
// Directed and randomized checks of the sobel row loader
// against hand-computed windows.
module tb_sobel_row_loader;
   import sobel_row_loader_pkg::*;

   localparam int W = SOBEL_IDATA_WIDTH;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [15:0]  cfg_num_rows;
   logic         srd2srow_valid;
   logic [W-1:0] srd2srow_data;
   logic         srow2srd_ready;
   logic [W-1:0] srow2sacc_row1_data;
   logic [W-1:0] srow2sacc_row2_data;
   logic [W-1:0] srow2sacc_row3_data;
   logic         srow2sacc_valid;
   logic         swt2srow_ready;
   logic         srow_strip_done;
   logic         srow_busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sobel_row_loader dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .cfg_num_rows        (cfg_num_rows),
      .srd2srow_valid      (srd2srow_valid),
      .srd2srow_data       (srd2srow_data),
      .srow2srd_ready      (srow2srd_ready),
      .srow2sacc_row1_data (srow2sacc_row1_data),
      .srow2sacc_row2_data (srow2sacc_row2_data),
      .srow2sacc_row3_data (srow2sacc_row3_data),
      .srow2sacc_valid     (srow2sacc_valid),
      .swt2srow_ready      (swt2srow_ready),
      .srow_strip_done     (srow_strip_done),
      .srow_busy           (srow_busy)
   );

   function automatic logic [W-1:0] seg(input logic [15:0] base,
                                        input int k);
      return {base, 32'(k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [143:0] obs,
                      input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_win(input string tag, input logic [15:0] base,
                          input int w);
      chk(tag, {srow2sacc_row1_data, srow2sacc_row2_data,
                srow2sacc_row3_data},
          {seg(base, w), seg(base, w + 1), seg(base, w + 2)});
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_valid"}, srow2sacc_valid, 0);
      chk({tag, "_ready"}, srow2srd_ready, 0);
      chk({tag, "_done"}, srow_strip_done, 0);
      chk({tag, "_busy"}, srow_busy, 0);
      chk({tag, "_rows"}, {srow2sacc_row1_data, srow2sacc_row2_data,
                           srow2sacc_row3_data}, 0);
   endtask

   // Runs one strip; windows are compared as they are consumed.
   task automatic run_strip(input string tag, input int n,
                            input bit rnd, input int mid,
                            input logic [15:0] base);
      int k;
      int w;
      int dn;
      int post;
      k = 0;
      w = 0;
      dn = 0;
      post = 0;
      start = 1'b1;
      cfg_num_rows = 16'(n);
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         srd2srow_valid = (k < n) && (!rnd || $urandom_range(0, 3) != 0);
         srd2srow_data = seg(base, k);
         swt2srow_ready = !rnd || $urandom_range(0, 2) != 0;
         start = (cyc == mid);
         cfg_num_rows = 16'd3;
         #1;
         if (srow2sacc_valid && swt2srow_ready) begin
            chk_win({tag, "_win"}, base, w);
            w++;
         end
         if (srow_strip_done) dn++;
         if (srd2srow_valid && srow2srd_ready) k++;
         if (dn > 0) post++;
         if (post > 3) break;
         tick();
      end
      start = 1'b0;
      srd2srow_valid = 1'b0;
      chk({tag, "_nwin"}, 144'(w), 144'(n - 2));
      chk({tag, "_ndone"}, 144'(dn), 144'd1);
      chk({tag, "_nacc"}, 144'(k), 144'(n));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      cfg_num_rows = '0;
      srd2srow_valid = 1'b0;
      srd2srow_data = '0;
      swt2srow_ready = 1'b0;
      tick();
      tick();
      chk_idle_zero("rst");
      reset = 1'b0;

      // Back-to-back 5-row strip
      start = 1'b1;
      cfg_num_rows = 16'd5;
      tick();
      start = 1'b0;
      srd2srow_valid = 1'b1;
      srd2srow_data = seg(16'hA000, 0);
      swt2srow_ready = 1'b1;
      #1;
      chk("s1_ready", srow2srd_ready, 1);
      chk("s1_busy", srow_busy, 1);
      chk("s1_novalid", srow2sacc_valid, 0);
      tick();
      srd2srow_data = seg(16'hA000, 1);
      tick();
      srd2srow_data = seg(16'hA000, 2);
      tick();
      srd2srow_data = seg(16'hA000, 3);
      #1;
      chk("s1_valid", srow2sacc_valid, 1);
      chk_win("s1_abc", 16'hA000, 0);
      tick();
      srd2srow_data = seg(16'hA000, 4);
      #1;
      chk_win("s1_bcd", 16'hA000, 1);
      tick();
      srd2srow_valid = 1'b0;
      #1;
      chk_win("s1_cde", 16'hA000, 2);
      chk("s1_drain_ready", srow2srd_ready, 0);
      chk("s1_drain_valid", srow2sacc_valid, 1);
      tick();
      chk("s1_done", srow_strip_done, 1);
      chk("s1_done_valid", srow2sacc_valid, 0);
      chk("s1_done_busy", srow_busy, 0);
      tick();
      chk("s1_done_pulse", srow_strip_done, 0);

      // Same strip with a 4-cycle consumer stall
      start = 1'b1;
      cfg_num_rows = 16'd5;
      tick();
      start = 1'b0;
      srd2srow_valid = 1'b1;
      srd2srow_data = seg(16'hB000, 0);
      tick();
      srd2srow_data = seg(16'hB000, 1);
      tick();
      srd2srow_data = seg(16'hB000, 2);
      tick();
      srd2srow_data = seg(16'hB000, 3);
      swt2srow_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("s2_stall_ready", srow2srd_ready, 0);
         chk("s2_stall_valid", srow2sacc_valid, 1);
         chk_win("s2_stall_abc", 16'hB000, 0);
         tick();
      end
      swt2srow_ready = 1'b1;
      #1;
      chk("s2_resume_ready", srow2srd_ready, 1);
      chk_win("s2_resume_abc", 16'hB000, 0);
      tick();
      srd2srow_data = seg(16'hB000, 4);
      #1;
      chk_win("s2_bcd", 16'hB000, 1);
      tick();
      srd2srow_valid = 1'b0;
      #1;
      chk_win("s2_cde", 16'hB000, 2);
      tick();
      chk("s2_done", srow_strip_done, 1);
      tick();

      // Too few rows: immediate done, no window
      start = 1'b1;
      cfg_num_rows = 16'd2;
      tick();
      start = 1'b0;
      #1;
      chk("s3_done", srow_strip_done, 1);
      chk("s3_busy", srow_busy, 0);
      chk("s3_valid", srow2sacc_valid, 0);
      chk("s3_ready", srow2srd_ready, 0);
      tick();
      chk("s3_done_pulse", srow_strip_done, 0);
      chk("s3_valid2", srow2sacc_valid, 0);

      // Extra start in the middle of a 6-row strip is ignored
      run_strip("s4", 6, 1'b0, 3, 16'hC000);

      // Reset after two accepted segments
      start = 1'b1;
      cfg_num_rows = 16'd5;
      tick();
      start = 1'b0;
      srd2srow_valid = 1'b1;
      srd2srow_data = seg(16'hD000, 0);
      tick();
      srd2srow_data = seg(16'hD000, 1);
      tick();
      srd2srow_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk_idle_zero("s5_rst");
      reset = 1'b0;
      tick();
      chk("s5_rst_nodone", srow_strip_done, 0);
      run_strip("s5", 3, 1'b0, -1, 16'h5A5A);

      // Randomized handshakes over 100 rows
      run_strip("s6", 100, 1'b1, -1, 16'h7700);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
